// File: rtl/stage5_types_pkg.sv
// Shared stage-boundary payload types for the 5-stage core and helpers
// used to size the elastic pipeline registers between stages.
package stage5_types_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  // Payload widths per stage boundary, derived from the struct definitions
  localparam int unsigned IF_ID_W  = $bits(if_id_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  // Pointer width for a DEPTH-entry ring; a single entry still needs one bit
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stage5_ptr_wrap.sv
// Ring-buffer pointer: increments modulo DEPTH when enabled, can be loaded.
module stage5_ptr_wrap
  import stage5_types_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [PTR_W-1:0] i_load_val,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_next_ptr;

  // Next value wraps back to zero after the last entry; DEPTH=1 pins at zero
  always_comb begin
    w_next_ptr = '0;
    if ((DEPTH > 1) && (r_ptr != PTR_W'(DEPTH - 1)))
      w_next_ptr = r_ptr + PTR_W'(1);
  end

  // Pointer register; load (flush realignment) wins over increment
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_ptr <= '0;
    else if (i_load)
      r_ptr <= i_load_val;
    else if (i_en)
      r_ptr <= w_next_ptr;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/stage5_elastic_pipe_reg.sv
// Elastic valid/ready pipeline register between two core stages: DEPTH-entry
// ring buffer with single-cycle flush and occupancy count.
module stage5_elastic_pipe_reg
  import stage5_types_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned READY_REG = 0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign out_valid = !empty && !flush;

  // Upstream ready: flush masks everything; otherwise optionally let a
  // same-cycle pop free a slot in a full buffer
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      if (READY_REG != 0)
        in_ready = !full;
      else
        in_ready = !full || out_ready;
    end
  end

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Occupancy update; flush empties regardless of handshakes
  always_comb begin
    w_count_next = r_count;
    if (flush)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + CNT_W'(1);
    else if (w_pop && !w_push)
      w_count_next = r_count - CNT_W'(1);
  end

  // Occupancy register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_count <= '0;
    else
      r_count <= w_count_next;
  end

  stage5_ptr_wrap #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_en       (w_push),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_ptr      (w_wr_ptr)
  );

  // Flush drops held entries by snapping the read pointer onto the write pointer
  stage5_ptr_wrap #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_en       (w_pop),
    .i_load     (flush),
    .i_load_val (w_wr_ptr),
    .o_ptr      (w_rd_ptr)
  );

  if (DEPTH == 1) begin : g_single
    logic [WIDTH-1:0] r_mem;

    // Single data slot, written on push, never reset
    always_ff @(posedge CLK) begin
      if (w_push)
        r_mem <= in_data;
    end

    assign out_data = r_mem;
  end else begin : g_ring
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Ring storage, written at the write pointer on push, never reset
    always_ff @(posedge CLK) begin
      if (w_push)
        r_mem[w_wr_ptr] <= in_data;
    end

    assign out_data = r_mem[w_rd_ptr];
  end

  a_count_bound : assert property (@(posedge CLK) disable iff (!nRST)
    r_count <= CNT_W'(DEPTH));

  a_no_pop_empty : assert property (@(posedge CLK) disable iff (!nRST)
    !(w_pop && empty));

endmodule

// File: tb/tb_stage5_elastic_pipe_reg.sv
// Bench for stage5_elastic_pipe_reg: four configurations checked against a
// queue model of the buffer contents.
module tb_stage5_elastic_pipe_reg;

  logic        CLK;
  logic        nRST;
  logic [3:0]  fl, iv, ordy;
  logic [31:0] id_flat;
  logic [3:0]  ir, ov, emp, ful;
  logic [31:0] od_flat;
  logic [1:0]  cnt0, cnt1;
  logic [2:0]  cnt2;
  logic [0:0]  cnt3;

  int checks = 0;
  int errors = 0;

  // inst0: D2/RR1, inst1: D2/RR0, inst2: D4/RR0, inst3: D1/RR1
  int dep[4] = '{2, 2, 4, 1};
  int rr[4]  = '{1, 0, 0, 1};

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  stage5_elastic_pipe_reg #(.WIDTH(8), .DEPTH(2), .READY_REG(1)) u_d0 (
    .CLK(CLK), .nRST(nRST), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id_flat[7:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od_flat[7:0]), .count(cnt0), .empty(emp[0]), .full(ful[0]));

  stage5_elastic_pipe_reg #(.WIDTH(8), .DEPTH(2), .READY_REG(0)) u_d1 (
    .CLK(CLK), .nRST(nRST), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id_flat[15:8]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od_flat[15:8]), .count(cnt1), .empty(emp[1]), .full(ful[1]));

  stage5_elastic_pipe_reg #(.WIDTH(8), .DEPTH(4), .READY_REG(0)) u_d2 (
    .CLK(CLK), .nRST(nRST), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id_flat[23:16]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od_flat[23:16]), .count(cnt2), .empty(emp[2]), .full(ful[2]));

  stage5_elastic_pipe_reg #(.WIDTH(8), .DEPTH(1), .READY_REG(1)) u_d3 (
    .CLK(CLK), .nRST(nRST), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_data(id_flat[31:24]), .out_valid(ov[3]), .out_ready(ordy[3]),
    .out_data(od_flat[31:24]), .count(cnt3), .empty(emp[3]), .full(ful[3]));

  function automatic int get_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  function automatic int msize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [7:0] mhead(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      2:       return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic mpush(input int k, input logic [7:0] v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      2:       q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic mpop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      2:       void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  task automatic mclear_all();
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
  endtask

  task automatic drv(input int k, input bit f, input bit v, input logic [7:0] d, input bit r);
    fl[k]             = f;
    iv[k]             = v;
    id_flat[8*k +: 8] = d;
    ordy[k]           = r;
  endtask

  // One clock of instance k: compare outputs with the model, clock, update model
  task automatic step(input int k, input string tag);
    int         sz;
    bit         fm;
    logic       eir;
    logic       eov;
    logic [7:0] eod;
    #1;
    sz  = msize(k);
    fm  = (sz == dep[k]);
    eir = fl[k] ? 1'b0 : ((rr[k] != 0) ? !fm : (!fm || ordy[k]));
    eov = (sz > 0) && !fl[k];
    checks++;
    if (ir[k] !== eir) begin
      errors++;
      $display("FAIL %s in_ready inst%0d got %b exp %b", tag, k, ir[k], eir);
    end
    checks++;
    if (ov[k] !== eov) begin
      errors++;
      $display("FAIL %s out_valid inst%0d got %b exp %b", tag, k, ov[k], eov);
    end
    checks++;
    if (get_cnt(k) != sz) begin
      errors++;
      $display("FAIL %s count inst%0d got %0d exp %0d", tag, k, get_cnt(k), sz);
    end
    checks++;
    if (emp[k] !== (sz == 0) || ful[k] !== fm) begin
      errors++;
      $display("FAIL %s empty/full inst%0d got %b/%b exp %b/%b", tag, k, emp[k], ful[k], (sz == 0), fm);
    end
    if (eov) begin
      eod = mhead(k);
      checks++;
      if (od_flat[8*k +: 8] !== eod) begin
        errors++;
        $display("FAIL %s out_data inst%0d got %0h exp %0h", tag, k, od_flat[8*k +: 8], eod);
      end
    end
    @(posedge CLK);
    if (fl[k]) begin
      case (k)
        0:       q0.delete();
        1:       q1.delete();
        2:       q2.delete();
        default: q3.delete();
      endcase
    end else begin
      if (eov && ordy[k]) mpop(k);
      if (iv[k] && eir) mpush(k, id_flat[8*k +: 8]);
    end
    @(negedge CLK);
  endtask

  task automatic drain(input int k, input string tag);
    drv(k, 0, 0, 8'h00, 1);
    for (int i = 0; i <= dep[k]; i++) step(k, tag);
    drv(k, 0, 0, 8'h00, 0);
  endtask

  task automatic test_reset();
    #2 nRST = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || get_cnt(k) != 0 || emp[k] !== 1'b1 || ful[k] !== 1'b0 || ir[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset inst%0d got ov=%b cnt=%0d emp=%b full=%b ir=%b exp 0/0/1/0/1",
                 k, ov[k], get_cnt(k), emp[k], ful[k], ir[k]);
      end
    end
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_fill();
    drv(0, 0, 1, 8'h0A, 0); step(0, "fill_a");
    drv(0, 0, 1, 8'h0B, 0); step(0, "fill_b");
    drv(0, 0, 1, 8'h0C, 0); step(0, "fill_third");
    step(0, "fill_hold");
    drain(0, "fill_drain");
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      drv(1, 0, 1, 8'(i), 1);
      step(1, "stream");
    end
    drain(1, "stream_drain");
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      drv(2, 0, 1, 8'(8'h10 + i), 0);
      step(2, "fpp_fill");
    end
    drv(2, 0, 1, 8'h14, 1); step(2, "fpp_both");
    drv(2, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(2, "fpp_pop");
    drv(2, 0, 0, 8'h00, 0);
  endtask

  task automatic test_flush();
    drv(1, 0, 1, 8'h20, 0); step(1, "flush_p0");
    drv(1, 0, 1, 8'h21, 0); step(1, "flush_p1");
    drv(1, 1, 1, 8'h22, 1); step(1, "flush_cyc");
    drv(1, 0, 0, 8'h00, 1); step(1, "flush_after");
    step(1, "flush_after2");
    drv(1, 0, 0, 8'h00, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drv(2, 0, 1, 8'(8'h40 + i), 0);
      step(2, "ares_fill");
    end
    drv(2, 0, 0, 8'h00, 0);
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (ov[2] !== 1'b0 || cnt2 !== 3'd0 || emp[2] !== 1'b1 || ir[2] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got ov=%b cnt=%0d emp=%b ir=%b exp 0/0/1/1", ov[2], cnt2, emp[2], ir[2]);
    end
    mclear_all();
    @(negedge CLK);
    nRST = 1'b1;
    drv(2, 0, 1, 8'h30, 0); step(2, "ares_push");
    drv(2, 0, 0, 8'h00, 1); step(2, "ares_first");
    step(2, "ares_empty");
    drv(2, 0, 0, 8'h00, 0);
  endtask

  task automatic test_depth1();
    int expc;
    drv(3, 0, 1, 8'h50, 1);
    for (int i = 0; i < 6; i++) begin
      id_flat[31:24] = 8'(8'h50 + i);
      step(3, "d1_alt");
      expc = (i % 2 == 0) ? 1 : 0;
      checks++;
      if (int'(cnt3) != expc) begin
        errors++;
        $display("FAIL d1_alternate cycle%0d count got %0d exp %0d", i, cnt3, expc);
      end
    end
    drain(3, "d1_drain");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 200; i++) begin
        drv(k, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), ($urandom_range(0, 2) != 0));
        step(k, "random");
      end
      drain(k, "random_drain");
    end
  endtask

  initial begin
    nRST    = 1'b1;
    fl      = '0;
    iv      = '0;
    ordy    = '0;
    id_flat = '0;
    test_reset();
    test_fill();
    test_stream();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    test_depth1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage5_elastic_pipe_reg.md
# stage5_elastic_pipe_reg

Parametrised elastic pipeline register for the 5-stage core, the generalised successor to the fixed execute→mem stage register. Holds up to DEPTH payloads of WIDTH bits between any two adjacent stages with a valid/ready handshake on both sides, a single-cycle flush, and an occupancy count. Instantiated once per stage boundary (fetch/decode, decode/execute, execute/mem, mem/writeback), with the stage struct packed into `in_data`/`out_data`.

## Interface
- `WIDTH`, default 32: payload width in bits (≥1).
- `DEPTH`, default 2: number of storage entries (power of two, ≥1).
- `READY_REG`, default 0: 0 means `in_ready` may depend combinationally on `out_ready`; 1 means `in_ready` is a function of registered state only.
- `CLK`, input, 1: single clock, rising edge.
- `nRST`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: discard all held entries; takes priority over every handshake.
- `in_valid`, input, 1: upstream stage presents `in_data`.
- `in_ready`, output, 1: this block accepts `in_data` this cycle.
- `in_data`, input, WIDTH: upstream payload.
- `out_valid`, output, 1: the head entry is presented on `out_data`.
- `out_ready`, input, 1: downstream stage consumes the head entry this cycle.
- `out_data`, output, WIDTH: head entry; undefined when `out_valid`=0.
- `count`, output, $clog2(DEPTH+1): current occupancy.
- `empty` / `full`, output, 1 each: `count`==0 and `count`==DEPTH.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each max(1,$clog2(DEPTH)) bits, wrapping modulo DEPTH. When DEPTH=1, both pointers stay at 0.
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- `out_valid` = !`empty` && !`flush`. `out_data` = mem[`rd_ptr`], driven straight from storage with no added mux stage.
- `in_ready`:
  - `flush`=1: 0.
  - READY_REG=0: !`full` || `out_ready`.
  - READY_REG=1: !`full`.
- Count update at each edge:
  - Push only: +1.
  - Pop only: −1.
  - Both: unchanged, with both pointers advancing.
  - Neither: hold.
- Flush: at the next edge, `count`←0 and `rd_ptr`←`wr_ptr`. Storage contents are not cleared. No push or pop occurs in the flush cycle, because both handshakes are masked.
- Push into a full buffer with a same-cycle pop is legal only when READY_REG=0. The slot being popped is overwritten at the edge.
- Overflow and underflow are unreachable by construction. Assertions flag `count`>DEPTH and any pop while `empty`.
- Reset (async, any time, including mid-transfer): `count`=0, both pointers=0, `out_valid`=0, `empty`=1, `full`=0. `in_ready` is 1 while `flush`=0, and returns to 1 immediately on reset assertion.

## Timing
- Latency: data pushed at edge k is visible on `out_data` with `out_valid`=1 in the cycle after edge k. The minimum is 1 cycle, with no combinational in→out path.
- Throughput: 1 transfer/cycle sustained for any DEPTH when READY_REG=0. With READY_REG=1, DEPTH≥2 is required for 1/cycle; DEPTH=1 gives 1 transfer per 2 cycles.
- Flush: effective in the same cycle for handshakes. `count`=0 after the edge. The first new push is possible in the cycle after `flush` deasserts.
- Combinational paths:
  - `out_ready`→`in_ready` exists only when READY_REG=0.
  - `flush`→`in_ready`/`out_valid` always exists.

## Structure
- The `stage5_types_pkg` package gains the per-boundary payload widths as localparams (e.g. EX_MEM_W = $bits(ex_mem_t)) so instantiations are sized from the struct definitions.
- Natural sub-module `stage5_ptr_wrap`: a pointer register with increment-and-wrap modulo DEPTH, async active-low reset, and an enable input. It is used for both `rd_ptr` and `wr_ptr`.
- Storage is a flop array inside the top module with no reset on data, only on control.

## Test plan
- Reset then fill, DEPTH=2, READY_REG=1, `out_ready`=0: push 0xA, then 0xB → `count` 1 then 2; `full`=1, `in_ready`=0; a third `in_valid` is not accepted.
- Streaming, DEPTH=2, READY_REG=0: 8 back-to-back pushes 0x1..0x8 with `out_ready`=1 → outputs 0x1..0x8 in order, one per cycle, each one cycle after its push; `count` stays at 1.
- Full with simultaneous push/pop, DEPTH=4, READY_REG=0: hold 0x10..0x13, push 0x14 while popping → pop returns 0x10, `count` stays 4, and the next four pops return 0x11..0x14. This covers pointer wrap.
- Flush: hold 0x20, 0x21, then assert `flush` with `in_valid`=1 (0x22) and `out_ready`=1 → `in_ready`=0 and `out_valid`=0 that cycle; `count`=0 after the edge; 0x22 is never output.
- Async reset mid-stream: assert `nRST`=0 between edges with `count`=3 → `out_valid`=0 and `count`=0 immediately; after release, a push of 0x30 appears as the first output.
- DEPTH=1, READY_REG=1, `out_ready`=1, continuous `in_valid` → accepts every other cycle, alternating `count` 1/0.
